// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    // Widest device count the onehot helper can produce.
    localparam int MAX_DRVRS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // One-hot vector with bit idx set, or zero when idx is outside [0,n).
    // Callers size-cast the result down to their own device count.
    function automatic logic [MAX_DRVRS-1:0] onehot(input int idx, input int n);
        logic [MAX_DRVRS-1:0] one;
        one = {{(MAX_DRVRS-1){1'b0}}, 1'b1};
        if (idx >= 0 && idx < n && idx < MAX_DRVRS)
            onehot = one << idx;
        else
            onehot = '0;
    endfunction

    // Round-robin pointer after reset: the last device, so the first
    // search starts at device 0.
    function automatic int rr_ptr_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin pick: first requester strictly after ptr, wrapping.
module rr_pick #(
    parameter  int drvrs = 4,
    localparam int id_w  = $clog2(drvrs)
) (
    input  logic [drvrs-1:0] req,
    input  logic [id_w-1:0]  ptr,
    output logic             any,
    output logic [id_w-1:0]  sel
);

    logic [drvrs-1:0] rot;
    logic [id_w-1:0]  first;

    // Rotate so that device ptr+1 lands at bit 0.
    always_comb begin
        logic [id_w-1:0] idx;
        rot = '0;
        idx = '0;
        for (int i = 0; i < drvrs; i++) begin
            idx    = id_w'((int'(ptr) + 1 + i) % drvrs);
            rot[i] = req[idx];
        end
    end

    // Fixed priority on the rotated vector: lowest index wins.
    always_comb begin
        first = '0;
        for (int i = drvrs - 1; i >= 0; i--)
            if (rot[i]) first = id_w'(i);
    end

    // Undo the rotation to get the real device index.
    always_comb begin
        any = |req;
        sel = id_w'((int'(ptr) + 1 + int'(first)) % drvrs);
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter and transfer sequencer: one grant at a time,
// pop on the first grant cycle, release on done or hold timeout, then a
// single turnaround cycle before the next arbitration.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int drvrs    = 4,
    parameter  int max_hold = 16,
    localparam int id_w     = $clog2(drvrs)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [drvrs-1:0] pndng,
    input  logic             done,
    output logic [drvrs-1:0] grant,
    output logic [id_w-1:0]  grant_id,
    output logic [drvrs-1:0] pop,
    output logic             busy,
    output logic             timeout
);

    localparam int              CNT_W   = $clog2(max_hold + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_hold);
    localparam logic [id_w-1:0]  RR_RST  = id_w'(rr_ptr_rst(drvrs));

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [id_w-1:0]  rr_ptr_q, rr_ptr_d;
    logic [drvrs-1:0] grant_d, pop_d, sel_oh;
    logic [id_w-1:0]  grant_id_d;
    logic             busy_d, timeout_d;
    logic             any;
    logic [id_w-1:0]  sel;

    rr_pick #(.drvrs(drvrs)) u_pick (
        .req (pndng),
        .ptr (rr_ptr_q),
        .any (any),
        .sel (sel)
    );

    assign sel_oh = drvrs'(onehot(int'(sel), drvrs));

    // Next state and next registered outputs; everything idles at zero.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        grant_id_d = '0;
        pop_d      = '0;
        busy_d     = 1'b0;
        timeout_d  = 1'b0;
        hold_d     = '0;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d    = BUSY;
                    grant_d    = sel_oh;
                    grant_id_d = sel;
                    pop_d      = sel_oh;
                    busy_d     = 1'b1;
                    hold_d     = CNT_W'(1);
                end
            end
            BUSY: begin
                // done has priority over the hold limit in the same cycle
                if (done || hold_q == CNT_MAX) begin
                    state_d   = GAP;
                    timeout_d = !done;
                    rr_ptr_d  = grant_id;
                end else begin
                    grant_d    = grant;
                    grant_id_d = grant_id;
                    busy_d     = 1'b1;
                    hold_d     = hold_q + CNT_W'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            rr_ptr_q <= RR_RST;
            grant    <= '0;
            grant_id <= '0;
            pop      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rr_ptr_q <= rr_ptr_d;
            grant    <= grant_d;
            grant_id <= grant_id_d;
            pop      <= pop_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
        end
    end

    a_grant_oh: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_pop_oh:   assert property (@(posedge clk) disable iff (reset) $onehot0(pop));
    a_pop_gnt:  assert property (@(posedge clk) disable iff (reset) (pop & ~grant) == '0);
    a_busy:     assert property (@(posedge clk) disable iff (reset) busy == (grant != '0));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus a random run against
// a transaction-level model (owner / age / last-served device).
module tb_bus_rr_arbiter;

    localparam int DRV  = 4;
    localparam int MAXH = 16;
    localparam int IDW  = $clog2(DRV);

    logic           clk = 1'b0;
    logic           reset;
    logic [DRV-1:0] pndng;
    logic           done;
    logic [DRV-1:0] grant;
    logic [IDW-1:0] grant_id;
    logic [DRV-1:0] pop;
    logic           busy;
    logic           timeout;

    int nvec = 0;
    int nerr = 0;

    // model state
    int m_owner = -1;
    int m_age   = 0;
    int m_last  = DRV - 1;
    bit m_gap   = 0;
    bit e_pop   = 0;
    bit e_to    = 0;

    bus_rr_arbiter #(.drvrs(DRV), .max_hold(MAXH)) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .done     (done),
        .grant    (grant),
        .grant_id (grant_id),
        .pop      (pop),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [DRV-1:0] exp_grant();
        logic [DRV-1:0] g;
        g = '0;
        if (m_owner >= 0) g = DRV'(1) << m_owner;
        return g;
    endfunction

    // Advance one clock and the model with the inputs seen at that edge.
    task automatic tick();
        bit found;
        int d;
        @(posedge clk);
        e_pop = 0;
        e_to  = 0;
        if (reset) begin
            m_owner = -1; m_age = 0; m_gap = 0; m_last = DRV - 1;
        end else if (m_owner >= 0) begin
            if (done || m_age == MAXH) begin
                e_to    = !done;
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (pndng != 0) begin
            found = 0;
            for (int k = 1; k <= DRV; k++) begin
                d = (m_last + k) % DRV;
                if (!found && pndng[d]) begin
                    m_owner = d;
                    found   = 1;
                end
            end
            m_age = 1;
            e_pop = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1; pndng = '0; done = 0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; pndng = '1; done = 1;
        tick(); tick();
        nvec++;
        if ({grant, pop, busy, timeout, grant_id} !== '0) begin
            nerr++;
            $display("FAIL reset: grant=%b pop=%b busy=%b timeout=%b id=%0d, want all 0",
                     grant, pop, busy, timeout, grant_id);
        end
        reset = 0; done = 0; pndng = '0;
        tick();
        nvec++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL idle_empty: grant=%b busy=%b, want 0000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        pndng = 4'b0001;
        tick();
        nvec++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || pop !== 4'b0001 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL single_grant: grant=%b id=%0d pop=%b busy=%b, want 0001/0/0001/1",
                     grant, grant_id, pop, busy);
        end
        tick();
        nvec++;
        if (grant !== 4'b0001 || pop !== 4'b0000) begin
            nerr++;
            $display("FAIL single_hold: grant=%b pop=%b, want 0001/0000", grant, pop);
        end
        pndng = '0; done = 1;
        tick();
        done = 0;
        nvec++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL single_gap: grant=%b busy=%b timeout=%b, want 0000/0/0",
                     grant, busy, timeout);
        end
        tick();
        nvec++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL single_idle: grant=%b busy=%b, want 0000/0", grant, busy);
        end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        pndng = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (busy !== 1'b1 || grant_id !== IDW'(order[i]) || grant !== (DRV'(1) << order[i])
                || pop !== grant) begin
                nerr++;
                $display("FAIL rotation[%0d]: grant=%b id=%0d pop=%b, want id %0d",
                         i, grant, grant_id, pop, order[i]);
            end
            tick();
            done = 1;
            tick();
            done = 0;
            nvec++;
            if (grant !== '0 || timeout !== 1'b0) begin
                nerr++;
                $display("FAIL rotation_gap[%0d]: grant=%b timeout=%b, want 0000/0", i, grant, timeout);
            end
            tick();
            nvec++;
            if (grant !== '0) begin
                nerr++;
                $display("FAIL rotation_idle[%0d]: grant=%b, want 0000", i, grant);
            end
        end
        pndng = '0;
        tick();
    endtask

    task automatic test_timeout();
        int held;
        do_reset();
        pndng = 4'b0100;
        held = 0;
        tick();
        while (grant === 4'b0100 && held < 40) begin
            held++;
            nvec++;
            if (timeout !== 1'b0) begin
                nerr++;
                $display("FAIL timeout_early: timeout=1 after %0d held cycles", held);
            end
            tick();
        end
        pndng = '0;
        nvec++;
        if (held != MAXH) begin
            nerr++;
            $display("FAIL timeout_len: held %0d cycles, want %0d", held, MAXH);
        end
        nvec++;
        if (timeout !== 1'b1 || grant !== '0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_pulse: timeout=%b grant=%b busy=%b, want 1/0000/0",
                     timeout, grant, busy);
        end
        tick();
        nvec++;
        if (timeout !== 1'b0) begin
            nerr++;
            $display("FAIL timeout_width: timeout=%b second cycle, want 0", timeout);
        end
        // device 2 was just released, so with 1 and 2 pending, 1 wins
        pndng = 4'b0110;
        tick();
        nvec++;
        if (grant !== 4'b0010) begin
            nerr++;
            $display("FAIL timeout_rrptr: grant=%b, want 0010", grant);
        end
        pndng = '0; done = 1;
        tick();
        done = 0;
        tick();
    endtask

    task automatic test_done_at_limit();
        do_reset();
        pndng = 4'b0010;
        tick();
        repeat (MAXH - 1) tick();
        nvec++;
        if (grant !== 4'b0010) begin
            nerr++;
            $display("FAIL limit_hold: grant=%b before release, want 0010", grant);
        end
        done = 1;
        tick();
        done = 0; pndng = '0;
        nvec++;
        if (timeout !== 1'b0 || grant !== '0) begin
            nerr++;
            $display("FAIL done_wins: timeout=%b grant=%b, want 0/0000", timeout, grant);
        end
        tick();
        nvec++;
        if (timeout !== 1'b0) begin
            nerr++;
            $display("FAIL done_wins_late: timeout=%b, want 0", timeout);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pndng = 4'b0010;
        tick();
        nvec++;
        if (grant !== 4'b0010) begin
            nerr++;
            $display("FAIL mid_grant: grant=%b, want 0010", grant);
        end
        tick();
        reset = 1;
        tick();
        reset = 0;
        nvec++;
        if ({grant, pop, busy, timeout, grant_id} !== '0) begin
            nerr++;
            $display("FAIL mid_reset: grant=%b pop=%b busy=%b timeout=%b id=%0d, want all 0",
                     grant, pop, busy, timeout, grant_id);
        end
        pndng = 4'b0011;
        tick();
        nvec++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            nerr++;
            $display("FAIL mid_regrant: grant=%b id=%0d, want 0001/0", grant, grant_id);
        end
        pndng = '0; done = 1;
        tick();
        done = 0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        pndng = 4'b1000;
        tick();
        nvec++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            nerr++;
            $display("FAIL wrap_g3: grant=%b id=%0d, want 1000/3", grant, grant_id);
        end
        done = 1;
        tick();
        pndng = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (grant !== '0 || timeout !== 1'b0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL idle_done[%0d]: grant=%b timeout=%b busy=%b, want 0", i, grant, timeout, busy);
            end
        end
        done = 0; pndng = 4'b1010;
        tick();
        nvec++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            nerr++;
            $display("FAIL wrap_next: grant=%b id=%0d, want 0010/1", grant, grant_id);
        end
        pndng = '0; done = 1;
        tick();
        done = 0;
        tick();
    endtask

    task automatic test_random();
        logic [DRV-1:0] eg;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            pndng = DRV'($urandom_range(0, 15));
            if (c < 2000) done = ($urandom_range(0, 5) == 0);
            else          done = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
            eg = exp_grant();
            nvec++;
            if (grant !== eg || busy !== (m_owner >= 0) || pop !== (e_pop ? eg : '0)
                || timeout !== e_to || (m_owner >= 0 && grant_id !== IDW'(m_owner))) begin
                nerr++;
                $display("FAIL random[%0d]: grant=%b id=%0d pop=%b busy=%b to=%b, want grant=%b id=%0d pop=%b to=%b",
                         c, grant, grant_id, pop, busy, timeout, eg, m_owner,
                         e_pop ? eg : '0, e_to);
            end
        end
        reset = 0; done = 0; pndng = '0;
    endtask

    initial begin
        reset = 1; pndng = '0; done = 0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
